// File: rtl/sim_test_sequencer.sv
// Test sequencer: pulses a DUT reset, waits a start delay, then runs each test
// method in index order over the req/busy/return handshake and reports the results.
module sim_test_sequencer #(
  parameter int N_TESTS     = 4,
  parameter int CNT_W       = 32,
  parameter int RESET_START = 3,
  parameter int RESET_LEN   = 6,
  parameter int START_DELAY = 100,
  parameter int GUARD       = 4,
  parameter int TIMEOUT     = 200000000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               dut_reset,
  output logic [N_TESTS-1:0] test_req,
  input  logic [N_TESTS-1:0] test_busy,
  input  logic [N_TESTS-1:0] test_return,
  output logic [4:0]         current_index,
  output logic               done,
  output logic               pass,
  output logic [N_TESTS-1:0] fail_mask,
  output logic               timeout_flag,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [2:0] {
    RSTGEN,
    ISSUE,
    ARM,
    RUN,
    NEXT,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] RST_FIRST  = CNT_W'(RESET_START);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_START + RESET_LEN - 1);
  localparam logic [CNT_W-1:0] START_AT   = CNT_W'(START_DELAY);
  localparam logic [CNT_W-1:0] GUARD_AT   = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       LAST_IDX   = 5'(N_TESTS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_tcnt;
  logic               r_dutReset;
  logic [N_TESTS-1:0] r_req;
  logic [4:0]         r_idx;
  logic               r_done;
  logic               r_pass;
  logic [N_TESTS-1:0] r_fail;
  logic               r_timeout;

  state_t             w_stateNext;
  logic [CNT_W-1:0]   w_countNext;
  logic [CNT_W-1:0]   w_tcntNext;
  logic               w_dutResetNext;
  logic [N_TESTS-1:0] w_reqNext;
  logic [4:0]         w_idxNext;
  logic               w_doneNext;
  logic               w_passNext;
  logic [N_TESTS-1:0] w_failNext;
  logic               w_timeoutNext;
  logic               w_busyCur;
  logic               w_retCur;
  logic               w_issue;
  logic [4:0]         w_issueIdx;
  logic               w_setFail;

  // Saturating counter keeps the start-delay compare valid forever.
  assign w_countNext    = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
  assign w_dutResetNext = (w_countNext >= RST_FIRST) && (w_countNext <= RST_LAST);

  always_comb begin
    w_busyCur = 1'b0;
    w_retCur  = 1'b0;
    for (int i = 0; i < N_TESTS; i++) begin
      if (r_idx == 5'(i)) begin
        w_busyCur = test_busy[i];
        w_retCur  = test_return[i];
      end
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_idxNext     = r_idx;
    w_tcntNext    = r_tcnt;
    w_timeoutNext = r_timeout;
    w_doneNext    = r_done;
    w_passNext    = r_pass;
    w_issue       = 1'b0;
    w_issueIdx    = r_idx;
    w_setFail     = 1'b0;
    case (r_state)
      RSTGEN: begin
        if (r_count >= START_AT) begin
          w_issue     = 1'b1;
          w_stateNext = ISSUE;
        end
      end
      ISSUE: begin
        w_tcntNext  = r_tcnt + 1'b1;
        w_stateNext = ARM;
      end
      ARM: begin
        w_tcntNext = r_tcnt + 1'b1;
        if (r_tcnt == TIMEOUT_AT) begin
          w_setFail     = 1'b1;
          w_timeoutNext = 1'b1;
          w_stateNext   = NEXT;
        end else if (r_tcnt >= GUARD_AT) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        w_tcntNext = r_tcnt + 1'b1;
        // A completion seen on the timeout cycle still counts as a completion.
        if (!w_busyCur) begin
          w_setFail   = !w_retCur;
          w_stateNext = NEXT;
        end else if (r_tcnt == TIMEOUT_AT) begin
          w_setFail     = 1'b1;
          w_timeoutNext = 1'b1;
          w_stateNext   = NEXT;
        end
      end
      NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_doneNext  = 1'b1;
          w_passNext  = (r_fail == '0) && !r_timeout;
          w_stateNext = FIN;
        end else begin
          w_idxNext   = r_idx + 5'd1;
          w_issueIdx  = r_idx + 5'd1;
          w_issue     = 1'b1;
          w_stateNext = ISSUE;
        end
      end
      FIN: begin
        w_stateNext = FIN;
      end
      default: begin
        w_stateNext = RSTGEN;
      end
    endcase
    if (w_issue) begin
      w_tcntNext = '0;
    end
  end

  always_comb begin
    w_reqNext  = '0;
    w_failNext = r_fail;
    for (int i = 0; i < N_TESTS; i++) begin
      if (w_issue && (w_issueIdx == 5'(i))) begin
        w_reqNext[i] = 1'b1;
      end
      if (w_setFail && (r_idx == 5'(i))) begin
        w_failNext[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RSTGEN;
      r_count    <= '0;
      r_tcnt     <= '0;
      r_dutReset <= 1'b0;
      r_req      <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_tcnt     <= w_tcntNext;
      r_dutReset <= w_dutResetNext;
      r_req      <= w_reqNext;
      r_idx      <= w_idxNext;
      r_done     <= w_doneNext;
      r_pass     <= w_passNext;
      r_fail     <= w_failNext;
      r_timeout  <= w_timeoutNext;
    end
  end

  assign dut_reset     = r_dutReset;
  assign test_req      = r_req;
  assign current_index = r_idx;
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail_mask     = r_fail;
  assign timeout_flag  = r_timeout;
  assign cycle_count   = r_count;

endmodule

// File: doc/sim_test_sequencer.md
# sim_test_sequencer

Synthesisable, parametrised test sequencer that replaces per-design hand-written simulation tops. It pulses a DUT reset, waits a start delay, then runs up to N_TESTS boolean test methods in index order using the compiler's req/busy/return method handshake. It records per-test pass/fail and timeouts, and raises a single done/pass summary. It sits between the clock/reset source and a generated DUT, either in simulation benches or on an FPGA driving status LEDs.

## Interface
Parameters:
- N_TESTS, 4: number of test-method channels (1..32).
- CNT_W, 32: width of the global cycle counter and timeout counter.
- RESET_START, 3: cycle at which dut_reset first asserts.
- RESET_LEN, 6: number of cycles dut_reset stays high (≥1).
- START_DELAY, 100: cycle index, counted from the sequencer's own reset, at which the first test may be issued. Must exceed RESET_START+RESET_LEN.
- GUARD, 4: minimum cycles after req before busy low is accepted as completion (≥1).
- TIMEOUT, 200000000: per-test cycle budget measured from req.

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high sequencer reset.
- dut_reset  out  1  generated reset for the DUT; active-high, registered.
- test_req  out  N_TESTS  one-cycle request pulse per test method.
- test_busy  in  N_TESTS  DUT method busy flags.
- test_return  in  N_TESTS  DUT boolean return values; sampled on completion.
- current_index  out  5  index of the test in progress, or last test after done.
- done  out  1  all tests finished; sticky until reset.
- pass  out  1  valid when done: 1 iff fail_mask==0 and no timeout.
- fail_mask  out  N_TESTS  bit i set if test i returned 0 or timed out.
- timeout_flag  out  1  sticky; any test exceeded TIMEOUT.
- cycle_count  out  CNT_W  free-running count since reset; saturates at all-ones.

## Operation
- Reset values: dut_reset=0, test_req=0, current_index=0, done=0, pass=0, fail_mask=0, timeout_flag=0, cycle_count=0. State is RSTGEN.
- cycle_count increments every cycle after reset.
- dut_reset is 1 exactly when RESET_START ≤ cycle_count ≤ RESET_START+RESET_LEN−1, taking effect on the next edge.
- State machine:
  - RSTGEN: wait until cycle_count ≥ START_DELAY, then go to ISSUE.
  - ISSUE: drive test_req[current_index]=1 for this cycle only, clear the timeout counter, then go to ARM.
  - ARM: count guard cycles. After GUARD cycles in ARM, go to RUN.
  - RUN: when test_busy[idx]==0, sample test_return[idx]. If the sampled value is 0, set fail_mask[idx]. Then go to NEXT.
  - RUN timeout: if the timeout counter reaches TIMEOUT−1 with busy still 1, set fail_mask[idx] and timeout_flag, then go to NEXT.
  - NEXT: if idx==N_TESTS−1, go to FIN. Otherwise increment idx and go to ISSUE.
  - FIN: done=1, and pass=(fail_mask==0). Remain in FIN until reset.
- The timeout counter also runs during ARM. A timeout firing in ARM is treated identically to one in RUN.
- Busy high in RUN or ARM is simply waited on. Busy glitches on non-current channels are ignored.
- Only one test_req bit is ever high, and only in the ISSUE-following cycle.
- Reset mid-operation returns everything to its reset values on the next edge. Any in-flight req is dropped. The DUT reset is re-pulsed by the new RSTGEN pass.
- cycle_count saturates and does not wrap. The RSTGEN compare therefore stays valid.

## Timing
- Registered outputs only; no combinational input-to-output paths.
- Reset deasserted at edge E0 gives cycle_count=1 at E1. dut_reset is high for exactly RESET_LEN cycles.
- First test_req rises one cycle after cycle_count reaches START_DELAY.
- A test whose busy falls at cycle B (B ≥ req+GUARD+1) has its result in fail_mask at B+1.
- The next req follows 2 cycles after that.
- done and pass assert together, 1 cycle after the final NEXT.
- Minimum per-test cost is GUARD+3 cycles.

## Test plan
- N_TESTS=1, DUT model busy for 50 cycles then return=1 → dut_reset high cycles 3–8; req at cycle 101; done=1, pass=1, fail_mask=0.
- N_TESTS=4, returns 1,0,1,1 → reqs strictly sequential, one-hot, one cycle wide; fail_mask=4'b0010, pass=0.
- N_TESTS=2, TIMEOUT=1000, test 0 busy never falls → timeout_flag=1 and fail_mask[0]=1 at req0+1000. Test 1 still runs; pass=0.
- DUT never raises busy, return=1, GUARD=4 → completion accepted at req+5; pass=1.
- Assert reset for 1 cycle while test 2 of 4 is in RUN → all outputs return to reset values. dut_reset re-pulses at cycles 3–8, and the sequence restarts from index 0.
- CNT_W=8, START_DELAY=200, TIMEOUT=50 → cycle_count saturates at 255 and never wraps. dut_reset does not re-pulse; done is still reached.
